// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM state encoding and
// default widths / reset PC used by ifu_fetch_ctrl.
package ifu_pkg;

    localparam int unsigned BUS_WIDTH_DEF   = 32;
    localparam int unsigned INSTR_WIDTH_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl_incr.sv
// Modulo-2^WIDTH incrementer used for PC sequencing; all-ones wraps to zero.
module ifu_fetch_ctrl_incr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] inc_o
);

    assign inc_o = val_i + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// PC sequencer and instruction-fetch controller with redirect draining.
// Define IFU_PREFETCH_EN to overlap the next fetch with the decode handover.
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter int unsigned          BUS_WIDTH   = BUS_WIDTH_DEF,
    parameter int unsigned          INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [BUS_WIDTH-1:0] RESET_PC    = BUS_WIDTH'(RESET_PC_DEF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [BUS_WIDTH-1:0]   redirect_pc,
    output logic                   imem_req,
    output logic [BUS_WIDTH-1:0]   imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [BUS_WIDTH-1:0]   instr_pc,
    output logic [BUS_WIDTH-1:0]   pc,
    output fetch_state_e           state_dbg
);

    fetch_state_e           state_q, state_d;
    logic [BUS_WIDTH-1:0]   pc_q, pc_d;
    logic                   req_q, req_d;
    logic [BUS_WIDTH-1:0]   addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [BUS_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic [BUS_WIDTH-1:0]   target_q, target_d;
    logic [BUS_WIDTH-1:0]   pc_inc;

    ifu_fetch_ctrl_incr #(.WIDTH(BUS_WIDTH)) u_pc_incr (
        .val_i (pc_q),
        .inc_o (pc_inc)
    );

`ifdef IFU_PREFETCH_EN
    logic [BUS_WIDTH-1:0] addr_inc;

    ifu_fetch_ctrl_incr #(.WIDTH(BUS_WIDTH)) u_addr_incr (
        .val_i (addr_q),
        .inc_o (addr_inc)
    );

    // The prefetch request exists only in the handover cycle, so it follows stall.
    assign imem_req = req_q | ((state_q == ST_HOLD) & ~stall);
`else
    assign imem_req = req_q;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        target_d   = target_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d   = redirect_pc;
                    addr_d = redirect_pc;
                end else begin
                    addr_d = pc_q;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_d   = redirect_pc;
                        addr_d = redirect_pc;
                    end else begin
                        instr_d    = imem_data;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        req_d      = 1'b0;
                        state_d    = ST_HOLD;
`ifdef IFU_PREFETCH_EN
                        addr_d     = pc_inc;
`endif
                    end
                end else if (redirect_valid) begin
                    target_d = redirect_pc;
                    state_d  = ST_DRAIN;
                end
            end
            ST_HOLD: begin
`ifdef IFU_PREFETCH_EN
                if (!stall) begin
                    // A request to addr_q (= pc+1) is on the bus this cycle.
                    if (redirect_valid) begin
                        valid_d = 1'b0;
                        req_d   = 1'b1;
                        if (imem_ack) begin
                            pc_d    = redirect_pc;
                            addr_d  = redirect_pc;
                            state_d = ST_REQ;
                        end else begin
                            target_d = redirect_pc;
                            state_d  = ST_DRAIN;
                        end
                    end else begin
                        pc_d = pc_inc;
                        if (imem_ack) begin
                            instr_d    = imem_data;
                            instr_pc_d = pc_inc;
                            addr_d     = addr_inc;
                        end else begin
                            req_d   = 1'b1;
                            valid_d = 1'b0;
                            state_d = ST_REQ;
                        end
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    addr_d  = redirect_pc;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
`else
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    addr_d  = redirect_pc;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
`endif
            end
            ST_DRAIN: begin
                // The old request must complete; its data is dropped.
                if (imem_ack) begin
                    pc_d    = redirect_valid ? redirect_pc : target_q;
                    addr_d  = redirect_valid ? redirect_pc : target_q;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else if (redirect_valid) begin
                    target_d = redirect_pc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            target_q   <= target_d;
        end
    end

    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;
    assign state_dbg   = state_q;

endmodule
